// File: rtl/sram_128b_port_ctrl_pkg.sv
// Shared definitions for the 128-bit SRAM port controller.
// Contents:
//   SRAM_DATA_W / SRAM_STRB_W / SRAM_ADDR_W : macro geometry
//   ctrl_state_e                            : controller FSM states
//   prio_e                                  : round-robin priority holder
//   merge_bytes()                           : per-byte select of new vs old data
package sram_128b_pkg;

    localparam int SRAM_DATA_W = 128;
    localparam int SRAM_STRB_W = SRAM_DATA_W / 8;
    localparam int SRAM_ADDR_W = 15;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_RMW_MERGE = 1'b1
    } ctrl_state_e;

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    // Bytes with a set strobe take new_data, the rest keep old_data.
    function automatic logic [SRAM_DATA_W-1:0] merge_bytes(
        input logic [SRAM_STRB_W-1:0] strb,
        input logic [SRAM_DATA_W-1:0] new_data,
        input logic [SRAM_DATA_W-1:0] old_data
    );
        logic [SRAM_DATA_W-1:0] merged;
        merged = old_data;
        for (int i = 0; i < SRAM_STRB_W; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_128b_port_ctrl_if.sv
// Requester-side bundle of the SRAM port controller.
// Channels (valid/ready, transfer when valid && ready; the source holds
// its payload stable while valid && !ready):
//   write    : wr_valid, wr_ready, wr_addr, wr_data, wr_strb
//   read     : rd_valid, rd_ready, rd_addr
//   response : rsp_valid, rsp_ready, rsp_data
// master = requester, slave = controller.
interface sram_128b_port_ctrl_if
    import sram_128b_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) ();

    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic [SRAM_DATA_W-1:0] wr_data;
    logic [SRAM_STRB_W-1:0] wr_strb;

    logic                   rd_valid;
    logic                   rd_ready;
    logic [ADDR_W-1:0]      rd_addr;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [SRAM_DATA_W-1:0] rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_strb,
        output rd_valid, rd_addr,
        output rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_strb,
        input  rd_valid, rd_addr,
        input  rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/sram_128b_port_ctrl_rsp_fifo.sv
// Synchronous FIFO holding read responses until the consumer takes them.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (drops contents)
//   push_i      : write push_data_i this cycle
//   pop_i       : remove the head entry this cycle
//   pop_data_o  : head entry (zero when empty)
//   count_o     : number of stored entries
//   empty_o     : no entries stored
module sram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 128,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_128b_port_ctrl.sv
// Front-end controller for the 128-bit single-port SRAM macro.
// Arbitrates the write and read channels of `bus` onto the one SRAM port,
// turns partial-strobe writes into read-modify-write, and returns read data
// through a response FIFO so consumer backpressure never loses data.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : write / read / response channels
//   sram_cen/wen      : macro chip enable / write enable
//   sram_addr/wdata   : macro address / write data
//   sram_wstrb        : macro byte strobes
//   sram_rdata        : macro read data, valid the cycle after a read issue
//   dbg_state_o       : current FSM state
module sram_128b_port_ctrl
    import sram_128b_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int RSP_DEPTH   = 3,
    parameter bit PARTIAL_RMW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_128b_port_ctrl_if.slave   bus,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic [SRAM_STRB_W-1:0] sram_wstrb,
    input  logic [DATA_W-1:0]      sram_rdata,
    output ctrl_state_e            dbg_state_o
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    ctrl_state_e state_q, state_d;
    prio_e       prio_q, prio_d;
    logic        rd_inflight_q, rd_inflight_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W:0]    occupancy;
    logic              rd_elig, wr_win, rd_win;
    logic              wr_ready_c, rd_ready_c, rsp_valid_c;

    // Slots already promised: stored responses plus the read whose data
    // arrives this cycle. A read is only granted if its response has a home.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rd_inflight_q);
    assign rd_elig   = bus.rd_valid && (occupancy < DEPTH_C);

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        rd_inflight_d = 1'b0;
        wr_win        = 1'b0;
        rd_win        = 1'b0;
        wr_ready_c    = 1'b0;
        rd_ready_c    = 1'b0;
        sram_cen      = 1'b0;
        sram_wen      = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;
        sram_wstrb    = '0;
        // During reset nothing is issued, so a pending RMW write is dropped.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    wr_win = bus.wr_valid && (!rd_elig || prio_q == PRIO_WR);
                    rd_win = rd_elig && (!bus.wr_valid || prio_q == PRIO_RD);
                    if (wr_win) begin
                        prio_d    = PRIO_RD;
                        sram_cen  = 1'b1;
                        sram_addr = bus.wr_addr;
                        if (bus.wr_strb == '1 || !PARTIAL_RMW) begin
                            sram_wen   = 1'b1;
                            sram_wdata = bus.wr_data;
                            sram_wstrb = bus.wr_strb;
                            wr_ready_c = 1'b1;
                        end else begin
                            // Fetch the old word; the request stays unacknowledged
                            // so its payload is still on the bus next cycle.
                            state_d = ST_RMW_MERGE;
                        end
                    end else if (rd_win) begin
                        prio_d        = PRIO_WR;
                        sram_cen      = 1'b1;
                        sram_addr     = bus.rd_addr;
                        rd_ready_c    = 1'b1;
                        rd_inflight_d = 1'b1;
                    end
                end
                ST_RMW_MERGE: begin
                    sram_cen   = 1'b1;
                    sram_wen   = 1'b1;
                    sram_addr  = bus.wr_addr;
                    sram_wdata = merge_bytes(bus.wr_strb, bus.wr_data, sram_rdata);
                    sram_wstrb = '1;
                    wr_ready_c = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prio_q        <= PRIO_WR;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    assign rsp_valid_c = !rst && !fifo_empty;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_inflight_q),
        .push_data_i (sram_rdata),
        .pop_i       (rsp_valid_c && bus.rsp_ready),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign bus.wr_ready  = wr_ready_c;
    assign bus.rd_ready  = rd_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_valid_c ? fifo_head : '0;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram_128b_port_ctrl.sv
// Directed bench for sram_128b_port_ctrl with a behavioural SRAM macro,
// a reference memory and a response scoreboard.
module tb_sram_128b_port_ctrl;
    import sram_128b_pkg::*;

    localparam int ADDR_W = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_128b_port_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    logic              sram_cen, sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [127:0]      sram_wdata;
    logic [127:0]      sram_rdata = '0;
    logic [15:0]       sram_wstrb;
    ctrl_state_e       dbg_state;

    sram_128b_port_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (128),
        .RSP_DEPTH   (3),
        .PARTIAL_RMW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_wstrb  (sram_wstrb),
        .sram_rdata  (sram_rdata),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt  = 0;

    logic [127:0] exp_q[$];
    logic [127:0] sram_mem [int];
    logic [127:0] ref_mem  [int];

    // Macro model: unstrobed bytes are written as zero; read data one cycle later.
    always @(posedge clk) begin
        if (sram_cen) begin
            if (sram_wen) begin
                logic [127:0] w;
                w = '0;
                for (int b = 0; b < 16; b++) if (sram_wstrb[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                sram_mem[int'(sram_addr)] = w;
            end else begin
                sram_rdata <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : '0;
            end
        end
    end

    function automatic logic [127:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Effect of an accepted write as seen by later reads.
    function automatic void ref_write(input int a, input logic [127:0] d, input logic [15:0] s);
        logic [127:0] w;
        w = ref_rd(a);
        for (int b = 0; b < 16; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a] = w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response handshake pops one expected word.
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL rsp_unexpected: observed %h expected none", bus.rsp_data);
            end else begin
                check("rsp_data", bus.rsp_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [127:0] d, input logic [15:0] s);
        bit done;
        done = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_W'(a);
        bus.wr_data  = d;
        bus.wr_strb  = s;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                done = 1'b1;
                ref_write(a, d, s);
            end
            step();
        end
        bus.wr_valid = 1'b0;
        check("wr_accept", done, 1'b1);
    endtask

    task automatic do_read(input int a);
        bit done;
        done = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = ADDR_W'(a);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.rd_ready) begin
                done = 1'b1;
                exp_q.push_back(ref_rd(a));
            end
            step();
        end
        bus.rd_valid = 1'b0;
        check("rd_accept", done, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cnt0;
        logic [127:0] d;
        logic [127:0] old_w;

        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
        bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b0;

        // Reset: requests present but nothing may be granted or issued.
        step();
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h5; bus.wr_data = '1; bus.wr_strb = '1;
        bus.rd_valid = 1'b1; bus.rd_addr = 15'h7;
        @(negedge clk);
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_rd_ready", bus.rd_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_cen", sram_cen, 1'b0);
        check("rst_wen", sram_wen, 1'b0);
        check("rst_addr", sram_addr, '0);
        check("rst_wdata", sram_wdata, '0);
        check("rst_wstrb", sram_wstrb, '0);
        check("rst_state", dbg_state, ST_IDLE);
        step();
        rst = 1'b0;
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.rsp_ready = 1'b1;
        step();

        // Full write then read back with minimum latency.
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h0010;
        bus.wr_data = 128'h00112233445566778899AABBCCDDEEFF; bus.wr_strb = 16'hFFFF;
        @(negedge clk);
        check("fw_wr_ready", bus.wr_ready, 1'b1);
        check("fw_cen", sram_cen, 1'b1);
        check("fw_wen", sram_wen, 1'b1);
        check("fw_addr", sram_addr, 15'h0010);
        check("fw_wdata", sram_wdata, 128'h00112233445566778899AABBCCDDEEFF);
        check("fw_wstrb", sram_wstrb, 16'hFFFF);
        if (bus.wr_ready) ref_write(32'h10, bus.wr_data, bus.wr_strb);
        step();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 15'h0010;
        @(negedge clk);
        check("rd_ready", bus.rd_ready, 1'b1);
        check("rd_cen", sram_cen, 1'b1);
        check("rd_wen", sram_wen, 1'b0);
        check("rd_addr", sram_addr, 15'h0010);
        if (bus.rd_ready) exp_q.push_back(128'h00112233445566778899AABBCCDDEEFF);
        step();
        bus.rd_valid = 1'b0;
        @(negedge clk);
        check("rsp_lat_t1", bus.rsp_valid, 1'b0);
        step();
        @(negedge clk);
        check("rsp_lat_t2", bus.rsp_valid, 1'b1);
        step();
        check("idle_cen", sram_cen, 1'b0);
        wait_drain();

        // Partial write becomes read-modify-write.
        do_write(32'h20, {16{8'hAA}}, 16'hFFFF);
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h0020;
        bus.wr_data = 128'h0123456789ABCDEF0123456789ABCD55; bus.wr_strb = 16'h0001;
        @(negedge clk);
        check("rmw_t0_wr_ready", bus.wr_ready, 1'b0);
        check("rmw_t0_cen", sram_cen, 1'b1);
        check("rmw_t0_wen", sram_wen, 1'b0);
        check("rmw_t0_addr", sram_addr, 15'h0020);
        step();
        @(negedge clk);
        check("rmw_t1_wr_ready", bus.wr_ready, 1'b1);
        check("rmw_t1_wen", sram_wen, 1'b1);
        check("rmw_t1_wstrb", sram_wstrb, 16'hFFFF);
        check("rmw_t1_wdata", sram_wdata, {{15{8'hAA}}, 8'h55});
        check("rmw_t1_state", dbg_state, ST_RMW_MERGE);
        if (bus.wr_ready) ref_write(32'h20, bus.wr_data, bus.wr_strb);
        step();
        bus.wr_valid = 1'b0;
        do_read(32'h20);
        wait_drain();

        // Backpressure: only three reads fit while the consumer stalls.
        for (int i = 0; i < 8; i++) do_write(32'h100 + i, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
        bus.rsp_ready = 1'b0;
        cnt0 = rsp_cnt;
        idx = 0;
        bus.rd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.rd_addr = ADDR_W'(32'h100 + idx);
            @(negedge clk);
            if (bus.rd_ready) begin
                exp_q.push_back(ref_rd(32'h100 + idx));
                idx++;
            end
            step();
        end
        check("bp_accepted", idx, 3);
        bus.rd_addr = ADDR_W'(32'h100 + idx);
        @(negedge clk);
        check("bp_rd_ready_low", bus.rd_ready, 1'b0);
        step();
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            bus.rd_addr = ADDR_W'(32'h100 + idx);
            @(negedge clk);
            if (bus.rd_ready) begin
                exp_q.push_back(ref_rd(32'h100 + idx));
                idx++;
            end
            step();
        end
        bus.rd_valid = 1'b0;
        check("bp_all_issued", idx, 8);
        wait_drain();
        check("bp_rsp_count", rsp_cnt - cnt0, 8);

        // Contention right after reset: grants alternate starting with write.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h0200; bus.wr_strb = 16'hFFFF;
        bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
        bus.rd_valid = 1'b1; bus.rd_addr = 15'h0200;
        for (int k = 0; k < 6; k++) begin
            bit wr_acc;
            @(negedge clk);
            check($sformatf("grant_%0d", k), {bus.wr_ready, bus.rd_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            wr_acc = bus.wr_ready;
            if (bus.wr_ready) ref_write(32'h200, bus.wr_data, bus.wr_strb);
            if (bus.rd_ready) exp_q.push_back(ref_rd(32'h200));
            step();
            if (wr_acc) bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        wait_drain();

        // Streaming: one read per cycle, responses continuous from cycle 2.
        cnt0 = rsp_cnt;
        for (int c = 0; c < 18; c++) begin
            bus.rd_valid = (c < 16);
            bus.rd_addr  = ADDR_W'(32'h100 + (c % 8));
            @(negedge clk);
            if (c < 16) begin
                check($sformatf("stream_rd_ready_%0d", c), bus.rd_ready, 1'b1);
                if (bus.rd_ready) exp_q.push_back(ref_rd(32'h100 + (c % 8)));
            end
            check($sformatf("stream_rsp_valid_%0d", c), bus.rsp_valid, (c >= 2));
            step();
        end
        bus.rd_valid = 1'b0;
        wait_drain();
        check("stream_rsp_count", rsp_cnt - cnt0, 16);

        // Reset during the merge cycle: the partial write must not land.
        old_w = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
        do_write(32'h40, old_w, 16'hFFFF);
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h0040; bus.wr_data = d; bus.wr_strb = 16'h00FF;
        @(negedge clk);
        check("mid_rmw_rd_cen", sram_cen, 1'b1);
        check("mid_rmw_rd_wen", sram_wen, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cen", sram_cen, 1'b0);
        check("mid_rst_wen", sram_wen, 1'b0);
        check("mid_rst_wr_ready", bus.wr_ready, 1'b0);
        step();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("post_rst_state", dbg_state, ST_IDLE);
        check("post_rst_cen", sram_cen, 1'b0);
        check("post_rst_addr", sram_addr, '0);
        check("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("post_rst_mem_kept", sram_mem.exists(32'h40) ? sram_mem[32'h40] : '0, old_w);
        step();
        do_read(32'h40);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_128b_port_ctrl.md
Name: sram_128b_port_ctrl

Overview:
Front-end controller for the 128-bit single-port SRAM macro in the iDMA/iNoC buffer. It takes independent valid/ready write and read request channels and arbitrates them onto the single SRAM port. It tracks the macro's 1-cycle read latency and returns read data on a valid/ready response channel through a small FIFO, so downstream backpressure never drops data. The macro writes zeros into unstrobed bytes, so partial-strobe writes are turned into read-modify-write sequences here.

Parameters:
ADDR_W, 15, SRAM word address width.
DATA_W, 128, data width; fixed at 128 to match the macro.
RSP_DEPTH, 3, response FIFO entries; must be >= 3 for full read throughput.
PARTIAL_RMW, 1, 1 = partial-strobe writes use RMW; 0 = strobe passed straight to the SRAM.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_valid  in  1  write request valid
wr_ready  out  1  write request accepted
wr_addr  in  ADDR_W  write word address
wr_data  in  128  write data
wr_strb  in  16  byte strobes
rd_valid  in  1  read request valid
rd_ready  out  1  read request accepted
rd_addr  in  ADDR_W  read word address
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_data  out  128  read data
sram_cen  out  1  SRAM chip enable
sram_wen  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  128  SRAM write data
sram_wstrb  out  16  SRAM strobes
sram_rdata  in  128  SRAM read data, valid the cycle after a read issue

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Handshakes: transfer occurs when valid && ready. Requesters hold payload stable while valid && !ready.
- SRAM-side outputs are combinational from the current grant. A request issues in the same cycle as its handshake, except the RMW write, which issues on the merge cycle.
- States:
  - IDLE: arbitrate and issue.
  - RMW_MERGE: complete a partial write.
- Read eligibility: rd_valid && (fifo_count + rd_inflight) < RSP_DEPTH. rd_inflight is a 1-bit register set in the cycle after a read issue.
- Write eligibility in IDLE: wr_valid.
- Arbitration when both are eligible: round-robin. The prio bit is set to the loser after each grant and resets to write-first. A single eligible requester is granted regardless of prio.
- Full write (wr_strb == 16'hFFFF, or PARTIAL_RMW == 0): sram_cen=1, sram_wen=1, addr/data/strb passed through; wr_ready=1 the same cycle; state stays IDLE.
- Partial write (PARTIAL_RMW == 1):
  - Cycle T: issue an SRAM read at wr_addr (cen=1, wen=0); wr_ready=0; go to RMW_MERGE.
  - Cycle T+1: write per byte merged = wr_strb ? wr_data : sram_rdata, with sram_wstrb = 16'hFFFF; wr_ready=1; go to IDLE.
  - No read is granted in RMW_MERGE.
  - The RMW read does not set rd_inflight and does not enter the FIFO.
  - wr_strb == 0 still performs the RMW, rewriting the old data unchanged.
- Read issue at cycle T: cen=1, wen=0, addr=rd_addr, rd_ready=1. At T+1, sram_rdata is pushed into the FIFO. rsp_valid is asserted from T+2. Minimum request-to-response latency is 2 cycles.
- Throughput: back-to-back reads sustain 1 per cycle while rsp_ready=1.
- FIFO push and pop in the same cycle leave count unchanged.
- Ordering: responses return in issue order. A write accepted after a read never affects that read's data.
- Idle cycle: sram_cen=0, sram_wen=0; sram_addr/wdata/wstrb = 0.
- Reset values:
  - wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0.
  - sram_cen=0, sram_wen=0, other SRAM outputs 0.
  - fifo_count=0, rd_inflight=0, state=IDLE, prio=write.
- Reset mid-operation: an in-flight read response or RMW is discarded and FIFO contents are lost. SRAM contents are not touched. A write in RMW_MERGE is not performed.

Decomposition:
- Package sram_128b_pkg:
  - SRAM_DATA_W=128, SRAM_STRB_W=16, default ADDR_W.
  - State enum {ST_IDLE, ST_RMW_MERGE}.
  - Byte-merge function (strb, new, old).
- Sub-module sram_rsp_fifo: parameterised synchronous FIFO (DEPTH, WIDTH) with push/pop/count/empty. It is instantiated once for the response path.

Test Plan:
- Full write then read: write addr 0x0010, data 0x0011..FF, strb FFFF; then read addr 0x0010 with rsp_ready=1 -> one SRAM write cycle, wr_ready same cycle; rsp_valid 2 cycles after the read handshake, rsp_data equals the written data.
- Partial RMW: preload 0x0020 = all 0xAA; write strb 0x0001, data 0x..55 -> SRAM read cycle then write cycle with wstrb FFFF; wr_ready only in the second cycle; readback = 0xAA..AA55.
- Backpressure: 8 back-to-back reads with rsp_ready=0 -> exactly 3 accepted, then rd_ready=0; raise rsp_ready -> all 8 responses return in order, no loss or duplication.
- Contention: wr_valid and rd_valid held high for 6 cycles, full-strobe writes -> grants alternate W,R,W,R,W,R starting with write after reset.
- Streaming: 16 reads with rsp_ready=1 -> one rd_ready per cycle; rsp_valid continuous from the 3rd cycle.
- Reset mid-RMW: assert rst in the RMW_MERGE cycle -> no SRAM write that cycle; all outputs 0 next cycle; the target address keeps its old value.
